// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a 33-cycle iterative multiply/divide unit.
// Multiply uses shift-add and divide uses restoring shift-subtract, both on operand magnitudes.
module hilo_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e      state_r;
  logic [4:0]  cnt_r;
  logic        is_div_r;
  logic        a_neg_r;
  logic        b_neg_r;
  logic [31:0] a_mag_r;
  logic [31:0] b_mag_r;
  logic [63:0] acc_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        start_signed_s;
  logic        start_a_neg_s;
  logic        start_b_neg_s;
  logic [31:0] start_a_mag_s;
  logic [31:0] start_b_mag_s;
  logic [63:0] start_acc_s;

  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [64:0] div_shift_s;
  logic [33:0] div_trial_s;
  logic [63:0] div_next_s;
  logic [63:0] iter_next_s;

  logic        sign_diff_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] dividend_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

  // Operand decode at launch: 0x80000000 negates to itself and is then used as unsigned.
  always_comb begin
    start_signed_s = ~op_i[0];
    start_a_neg_s  = start_signed_s & rs_i[31];
    start_b_neg_s  = start_signed_s & rt_i[31];
    start_a_mag_s  = start_a_neg_s ? (32'd0 - rs_i) : rs_i;
    start_b_mag_s  = start_b_neg_s ? (32'd0 - rt_i) : rt_i;
    if (op_i[1]) begin
      start_acc_s = {32'd0, start_a_mag_s};
    end else begin
      start_acc_s = {32'd0, start_b_mag_s};
    end
  end

  // One iteration: multiply adds into the upper half and shifts right; divide shifts left and trial-subtracts.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, a_mag_r} : 33'd0);
    mul_next_s  = {mul_sum_s, acc_r[31:1]};
    div_shift_s = {acc_r, 1'b0};
    div_trial_s = {1'b0, div_shift_s[64:32]} - {2'b00, b_mag_r};
    if (div_trial_s[33]) begin
      div_next_s = div_shift_s[63:0];
    end else begin
      div_next_s = {div_trial_s[31:0], div_shift_s[31:1], 1'b1};
    end
    if (is_div_r) begin
      iter_next_s = div_next_s;
    end else begin
      iter_next_s = mul_next_s;
    end
  end

  // Sign correction and divide-by-zero substitution for the commit edge.
  always_comb begin
    sign_diff_s = a_neg_r ^ b_neg_r;
    prod_fix_s  = sign_diff_s ? (64'd0 - acc_r) : acc_r;
    quot_fix_s  = sign_diff_s ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
    rem_fix_s   = a_neg_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
    dividend_s  = a_neg_r ? (32'd0 - a_mag_r) : a_mag_r;
    if (!is_div_r) begin
      fix_hi_s = prod_fix_s[63:32];
      fix_lo_s = prod_fix_s[31:0];
    end else if (b_mag_r == 32'd0) begin
      fix_hi_s = dividend_s;
      fix_lo_s = 32'hFFFF_FFFF;
    end else begin
      fix_hi_s = rem_fix_s;
      fix_lo_s = quot_fix_s;
    end
  end

  // Control FSM with registered busy/done and the HI/LO registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 5'd0;
      is_div_r <= 1'b0;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      a_mag_r  <= 32'd0;
      b_mag_r  <= 32'd0;
      acc_r    <= 64'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            is_div_r <= op_i[1];
            a_neg_r  <= start_a_neg_s;
            b_neg_r  <= start_b_neg_s;
            a_mag_r  <= start_a_mag_s;
            b_mag_r  <= start_b_mag_s;
            acc_r    <= start_acc_s;
            cnt_r    <= 5'd0;
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            if (hi_we_i) begin
              hi_r <= wdata_i;
            end
            if (lo_we_i) begin
              lo_r <= wdata_i;
            end
          end
        end
        ST_RUN: begin
          acc_r <= iter_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_r;
  assign done_o = done_r;
  assign hi_o   = hi_r;
  assign lo_o   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus random ops against an arithmetic reference.
module tb_hilo_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  hilo_muldiv dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int sa;
    int sb;
    int q;
    int r;
    case (op)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge in IDLE; launches an op and checks timing, hold and result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input bit disturb);
    int n;
    op_i = op;
    rs_i = a;
    rt_i = b;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      if (n == 16) begin
        chk({tag, "_hold"}, {hi_o, lo_o}, {mdl_hi, mdl_lo});
        chk({tag, "_nodone"}, 64'(done_o), 64'd0);
      end
      if (disturb && n == 5) begin
        start_i = 1'b1;
        hi_we_i = 1'b1;
        lo_we_i = 1'b1;
        wdata_i = 32'hDEAD_BEEF;
        rs_i    = 32'd99;
        op_i    = 2'd3;
      end else if (disturb && n == 6) begin
        start_i = 1'b0;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
      end
      @(negedge clk_i);
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    chk({tag, "_hilo"}, {hi_o, lo_o}, exp);
    mdl_hi = exp[63:32];
    mdl_lo = exp[31:0];
    @(negedge clk_i);
    chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int seen;
    logic [1:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_i = 1'b1;
    start_i = 1'b0;
    op_i = 2'd0;
    rs_i = 32'd0;
    rt_i = 32'd0;
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    wdata_i = 32'd0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("reset_state", {28'd0, busy_o, done_o, 2'b00, hi_o, lo_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_op("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
    run_op("div_neg7by2", 2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0);
    run_op("divu_by0", 2'd3, 32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF}, 1'b0);
    run_op("div_by0", 2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0);

    // MTHI/MTLO together
    hi_we_i = 1'b1;
    lo_we_i = 1'b1;
    wdata_i = 32'h1234;
    @(negedge clk_i);
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    chk("mthi_mtlo", {hi_o, lo_o}, {32'h1234, 32'h1234});
    mdl_hi = 32'h1234;
    mdl_lo = 32'h1234;

    // Start together with a write: start wins, write dropped (hold check inside run_op).
    hi_we_i = 1'b1;
    wdata_i = 32'h5555_AAAA;
    run_op("start_wins", 2'd1, 32'd3, 32'd4, {32'd0, 32'd12}, 1'b0);
    hi_we_i = 1'b0;
    hi_we_i = 1'b1;
    lo_we_i = 1'b1;
    wdata_i = 32'h1234;
    @(negedge clk_i);
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    mdl_hi = 32'h1234;
    mdl_lo = 32'h1234;

    run_op("mult_5x6_disturb", 2'd0, 32'd5, 32'd6, {32'd0, 32'h1E}, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      run_op($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), rop, ra, rb, ref_op(rop, ra, rb), 1'b0);
    end

    // Reset in the middle of an operation.
    op_i = 2'd1;
    rs_i = 32'd77;
    rt_i = 32'd88;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("midrun_reset", {31'd0, busy_o, hi_o, lo_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_hilo", {hi_o, lo_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
